// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: radix-2 multi-cycle MULT/MULTU/DIV/DIVU engine that sits
// beside the execute-stage ALU. It holds the pipeline while it iterates and
// hands back a HI/LO pair. The radix-2 step works on magnitudes; the signs
// are applied to the result in the same cycle as the last step.
module ex_muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              op_div_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] opa_i,
  input  logic [DATA_W-1:0] opb_i,
  input  logic              annul_i,
  output logic              busy_o,
  output logic              stallreq_o,
  output logic              ready_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);
  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                is_div, sa, sb;
  // opm: multiplicand (mul) or divisor (div) magnitude, fixed for the whole op
  logic [DATA_W-1:0]   opm;
  // acc: mul = {partial product, remaining multiplier bits}
  //      div = {partial remainder, dividend bits shifting into quotient}
  logic [2*DATA_W-1:0] acc;

  logic                launch, div_zero, last_iter;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     add_sum, shl, diff;
  logic [2*DATA_W-1:0] mul_step, div_step, acc_step, prod_fix;
  logic [DATA_W-1:0]   hi_fix, lo_fix;

  assign launch    = (state == IDLE) && start_i && !annul_i;
  assign div_zero  = op_div_i && (opb_i == '0);
  assign last_iter = (state == CALC) && !annul_i && (cnt == LAST_CNT);
  assign a_mag     = (signed_i && opa_i[DATA_W-1]) ? -opa_i : opa_i;
  assign b_mag     = (signed_i && opb_i[DATA_W-1]) ? -opb_i : opb_i;

  // One radix-2 iteration of both algorithms; is_div picks which one applies.
  always_comb begin
    add_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opm} : '0);
    mul_step = {add_sum, acc[DATA_W-1:1]};
    // Partial remainder stays below the divisor, so shl - opm fits in
    // DATA_W+1 bits and its MSB is a reliable "would go negative" flag.
    shl      = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    diff     = shl - {1'b0, opm};
    div_step = diff[DATA_W] ? {shl[DATA_W-1:0],  acc[DATA_W-2:0], 1'b0}
                            : {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
    acc_step = is_div ? div_step : mul_step;
  end

  // Sign correction of the final step's result; MIN/-1 wraps naturally.
  always_comb begin
    prod_fix = (sa ^ sb) ? -acc_step : acc_step;
    if (is_div) begin
      lo_fix = (sa ^ sb) ? -acc_step[DATA_W-1:0] : acc_step[DATA_W-1:0];
      hi_fix = sa ? -acc_step[2*DATA_W-1:DATA_W] : acc_step[2*DATA_W-1:DATA_W];
    end else begin
      lo_fix = prod_fix[DATA_W-1:0];
      hi_fix = prod_fix[2*DATA_W-1:DATA_W];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and control outputs.
  always_comb begin
    state_nxt  = state;
    busy_o     = (state != IDLE);
    stallreq_o = 1'b0;
    ready_o    = 1'b0;
    case (state)
      IDLE: begin
        stallreq_o = launch;
        if (launch) state_nxt = div_zero ? DONE : CALC;
      end
      CALC: begin
        stallreq_o = 1'b1;
        if (annul_i)                state_nxt = IDLE;
        else if (cnt == LAST_CNT)   state_nxt = DONE;
      end
      DONE: begin
        ready_o   = !annul_i;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Iteration counter.
  always_ff @(posedge clk) begin
    if (rst)                 cnt <= '0;
    else if (launch)         cnt <= '0;
    else if (state == CALC)  cnt <= cnt + CNT_W'(1);
  end

  // Operand capture and per-cycle iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_div <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      opm    <= '0;
      acc    <= '0;
    end else if (launch) begin
      is_div <= op_div_i;
      sa     <= signed_i & opa_i[DATA_W-1];
      sb     <= signed_i & opb_i[DATA_W-1];
      opm    <= op_div_i ? b_mag : a_mag;
      acc    <= {{DATA_W{1'b0}}, (op_div_i ? a_mag : b_mag)};
    end else if (state == CALC) begin
      acc    <= acc_step;
    end
  end

  // HI/LO result registers: written only on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (launch && div_zero) begin
      hi_o <= opa_i;
      lo_o <= '1;
    end else if (last_iter) begin
      hi_o <= hi_fix;
      lo_o <= lo_fix;
    end
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Multi-cycle multiply/divide engine beside the execute-stage ALU.
- Handles MIPS MULT/MULTU/DIV/DIVU with radix-2 iteration, one bit per cycle.
- Raises a stall request to the pipeline while computing and presents a HI/LO result pair for the HI/LO write-back path.
- Operand and result widths are parametrised.

Parameters:
- DATA_W, 32, operand width; hi_o/lo_o are each DATA_W bits.
- CNT_W, $clog2(DATA_W)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  request a new operation; sampled only in IDLE.
- op_div_i  in  1  0 = multiply, 1 = divide.
- signed_i  in  1  1 = two's-complement operands, 0 = unsigned.
- opa_i  in  DATA_W  multiplicand / dividend.
- opb_i  in  DATA_W  multiplier / divisor.
- annul_i  in  1  pipeline flush; aborts any operation in progress.
- busy_o  out  1  high in CALC and DONE.
- stallreq_o  out  1  pipeline stall request.
- ready_o  out  1  one-cycle pulse; hi_o/lo_o are valid.
- hi_o  out  DATA_W  product upper half / remainder.
- lo_o  out  DATA_W  product lower half / quotient.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, counter=0, hi_o=0, lo_o=0, ready_o=0, busy_o=0. Reset overrides every other input, including mid-operation.
- States:
  - IDLE: start_i=1 and annul_i=0 latches operands.
    - Divide with opb_i==0 goes to DONE.
    - Otherwise goes to CALC with counter=0.
  - CALC: one iteration per cycle. After DATA_W iterations (counter==DATA_W-1 at the edge) goes to DONE.
  - DONE: ready_o=1 for this single cycle, hi_o/lo_o already updated; unconditionally returns to IDLE.
- Latency:
  - Normal op: ready_o is high in cycle N+DATA_W+1, where start was sampled in cycle N (33 cycles for DATA_W=32).
  - Divide-by-zero: ready_o is high in cycle N+1.
- Signed handling:
  - At start, operands are converted to magnitudes and the signs sa=opa msb, sb=opb msb are stored when signed_i=1.
  - Results are corrected on entry to DONE:
    - Product negated (2*DATA_W wide) if sa^sb.
    - Quotient negated if sa^sb.
    - Remainder negated if sa.
- Arithmetic:
  - Multiply: shift-add into a 2*DATA_W accumulator; hi_o:lo_o = full product.
  - Divide: restoring division; lo_o=quotient, hi_o=remainder.
  - Signed MIN/-1 (e.g. 0x80000000 / 0xFFFFFFFF) wraps: lo_o=0x80000000, hi_o=0.
  - Divide-by-zero: hi_o=opa_i as given (unconverted), lo_o=all ones.
- Result hold: hi_o/lo_o keep their value from DONE until the next DONE. They change only on DONE entry.
- stallreq_o = (IDLE and start_i and not annul_i) or CALC. It is low in DONE so the pipeline advances in the ready cycle.
- start_i is ignored in CALC and DONE; no queueing.
- annul_i:
  - In CALC or DONE: next state IDLE, ready_o low that cycle, hi_o/lo_o unchanged.
  - annul_i and start_i together in IDLE: the start is ignored.
- busy_o = (state != IDLE).

Test Plan:
1. Unsigned multiply 0xFFFFFFFF × 0xFFFFFFFF → hi_o=0xFFFFFFFE, lo_o=0x00000001. ready_o is a single pulse 33 cycles after start; stallreq_o is high from the start cycle through the last CALC cycle.
2. Signed multiply -3 × 7 → hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB. A start_i held high for the whole run launches only one operation.
3. Signed divide -7 / 2 → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. Unsigned divide 100 / 7 → lo_o=14, hi_o=2. Signed 0x80000000 / 0xFFFFFFFF → lo_o=0x80000000, hi_o=0.
4. Divide 5 / 0 → ready_o pulses one cycle after start, hi_o=5, lo_o=0xFFFFFFFF, and the stall lasts only the start cycle.
5. annul_i pulsed at iteration 10 of a multiply → no ready_o, hi_o/lo_o keep their previous result, and a start on the next cycle completes normally.
6. rst asserted mid-CALC → next cycle state IDLE, hi_o=lo_o=0, busy_o=0, ready_o never pulses.
